// File: rtl/prog_loader_if.sv
// Byte-stream handshake between the host/UART byte source
// and the boot loader.
interface prog_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: frames a byte stream into imem words, checks
// an XOR checksum, and holds the core in reset until done.
module prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      strm,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC);
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        acc_q, acc_d;
  logic [23:0]       word_q, word_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              crst_q, crst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic              xfer;
  logic              timed;
  logic [15:0]       n_new;
  logic [ADDR_W:0]   cnt_inc;
  logic [TW-1:0]     tmo_inc;

  assign strm.s_ready = reset &&
    (state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM});
  assign xfer  = strm.s_valid && strm.s_ready;
  assign timed = state_q inside {S_LEN_HI, S_DATA, S_CSUM};

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_reset   = crst_q;
  assign words_loaded = cnt_q;
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);

  // Frame parser, word assembly, checksum and idle timeout
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    n_new   = {strm.s_data, len_q[7:0]};
    cnt_inc = cnt_q + (ADDR_W+1)'(1);
    tmo_inc = tmo_q + TW'(1);
    // core leaves reset one cycle after DONE is entered
    crst_d  = !(state_q == S_DONE && !restart);

    unique case (state_q)
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, strm.s_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = n_new;
          if (n_new == 16'd0)
            state_d = S_CSUM;
          else if ({1'b0, n_new} > MAX_N)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          acc_d  = acc_q ^ strm.s_data;
          lane_d = lane_q + 2'd1;
          word_d = {strm.s_data, word_q[23:8]};
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = cnt_q[ADDR_W-1:0];
            wdata_d = {strm.s_data, word_q};
            cnt_d   = cnt_inc;
            if (17'(cnt_inc) == {1'b0, len_q})
              state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (xfer)
          state_d = (strm.s_data == acc_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d = S_LEN_LO;
          cnt_d   = '0;
          lane_d  = '0;
          acc_d   = '0;
          word_d  = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = S_ERR;
    endcase

    if (timed) begin
      tmo_d = xfer ? '0 : tmo_inc;
      if (!xfer && tmo_inc == TMO_LAST)
        state_d = S_ERR;
    end
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_LEN_LO;
      len_q   <= '0;
      lane_q  <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
